// File: rtl/saph_fpu_xbar.sv
// saph_fpu_xbar: round-robin crossbar coupling requester ports to identical,
// fixed-latency FP units, with per-unit tag pipelines routing results back.
// Ports:
//   clk_i, rst_i         clock, async active-high reset
//   req_valid_i/ready_o  per-port request handshake (ready is combinational)
//   req_op_i/a_i/b_i     per-port opcode and operands, port p at [p*W +: W]
//   resp_valid_o/data_o  per-port registered result pulse
//   u_valid_o/op_o/a_o/b_o  registered issue bus per unit
//   u_res_valid_i/u_res_i   unit result inputs
//   err_o                sticky tag/result mismatch flag
module saph_fpu_xbar #(
  parameter int unsigned ports    = 2,
  parameter int unsigned units    = 2,
  parameter int unsigned width    = 32,
  parameter int unsigned op_width = 3,
  parameter int unsigned latency  = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [ports-1:0]           req_valid_i,
  output logic [ports-1:0]           req_ready_o,
  input  logic [ports*op_width-1:0]  req_op_i,
  input  logic [ports*width-1:0]     req_a_i,
  input  logic [ports*width-1:0]     req_b_i,
  output logic [ports-1:0]           resp_valid_o,
  output logic [ports*width-1:0]     resp_data_o,
  output logic [units-1:0]           u_valid_o,
  output logic [units*op_width-1:0]  u_op_o,
  output logic [units*width-1:0]     u_a_o,
  output logic [units*width-1:0]     u_b_o,
  input  logic [units-1:0]           u_res_valid_i,
  input  logic [units*width-1:0]     u_res_i,
  output logic                       err_o
);

  localparam int unsigned port_w = (ports > 1) ? $clog2(ports) : 1;

  logic [port_w-1:0]         ptr_q, ptr_d;
  logic [ports-1:0]          grant_c;
  logic [units-1:0]          assign_c;
  logic [port_w-1:0]         unit_port_c [units];
  logic [op_width-1:0]       sel_op_c    [units];
  logic [width-1:0]          sel_a_c     [units];
  logic [width-1:0]          sel_b_c     [units];

  logic [units-1:0]          u_valid_q;
  logic [units*op_width-1:0] u_op_q;
  logic [units*width-1:0]    u_a_q;
  logic [units*width-1:0]    u_b_q;
  logic [port_w-1:0]         u_port_q    [units];

  logic [latency-1:0]        tag_v_q     [units];
  logic [port_w-1:0]         tag_p_q     [units][latency];

  logic [ports-1:0]          resp_hit_c;
  logic [width-1:0]          resp_res_c  [ports];
  logic                      err_c;
  logic [ports-1:0]          resp_valid_q;
  logic [ports*width-1:0]    resp_data_q;
  logic                      err_q;

  // Rotating-priority scan: each valid port, starting at ptr, takes the
  // lowest free unit until units run out.
  always_comb begin
    int unsigned nxt;
    int unsigned idx;
    grant_c  = '0;
    assign_c = '0;
    ptr_d    = ptr_q;
    nxt      = 0;
    idx      = 0;
    for (int unsigned k = 0; k < units; k++) unit_port_c[k] = '0;
    for (int unsigned i = 0; i < ports; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= ports) idx = idx - ports;
      for (int unsigned p = 0; p < ports; p++) begin
        if (p == idx && req_valid_i[p] && nxt < units) begin
          grant_c[p] = 1'b1;
          for (int unsigned k = 0; k < units; k++) begin
            if (k == nxt) begin
              assign_c[k]    = 1'b1;
              unit_port_c[k] = port_w'(p);
            end
          end
          nxt   = nxt + 1;
          ptr_d = (p == ports - 1) ? '0 : port_w'(p + 1);
        end
      end
    end
  end

  // Per-unit operand mux from the assigned port.
  always_comb begin
    for (int unsigned k = 0; k < units; k++) begin
      sel_op_c[k] = '0;
      sel_a_c[k]  = '0;
      sel_b_c[k]  = '0;
      for (int unsigned p = 0; p < ports; p++) begin
        if (unit_port_c[k] == port_w'(p)) begin
          sel_op_c[k] = req_op_i[p*op_width +: op_width];
          sel_a_c[k]  = req_a_i[p*width +: width];
          sel_b_c[k]  = req_b_i[p*width +: width];
        end
      end
    end
  end

  // Tag output must agree with the unit's result strobe; a result without a
  // tag is dropped, a tag without a result is consumed silently.
  always_comb begin
    resp_hit_c = '0;
    err_c      = 1'b0;
    for (int unsigned p = 0; p < ports; p++) resp_res_c[p] = '0;
    for (int unsigned k = 0; k < units; k++) begin
      if (tag_v_q[k][latency-1] != u_res_valid_i[k]) err_c = 1'b1;
      if (tag_v_q[k][latency-1] && u_res_valid_i[k]) begin
        for (int unsigned p = 0; p < ports; p++) begin
          if (tag_p_q[k][latency-1] == port_w'(p)) begin
            resp_hit_c[p] = 1'b1;
            resp_res_c[p] = u_res_i[k*width +: width];
          end
        end
      end
    end
  end

  // Pointer, issue stage and tag pipelines.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q     <= '0;
      u_valid_q <= '0;
      u_op_q    <= '0;
      u_a_q     <= '0;
      u_b_q     <= '0;
      for (int unsigned k = 0; k < units; k++) begin
        u_port_q[k] <= '0;
        tag_v_q[k]  <= '0;
        for (int unsigned s = 0; s < latency; s++) tag_p_q[k][s] <= '0;
      end
    end else begin
      ptr_q     <= ptr_d;
      u_valid_q <= assign_c;
      for (int unsigned k = 0; k < units; k++) begin
        if (assign_c[k]) begin
          u_op_q[k*op_width +: op_width] <= sel_op_c[k];
          u_a_q[k*width +: width]        <= sel_a_c[k];
          u_b_q[k*width +: width]        <= sel_b_c[k];
          u_port_q[k]                    <= unit_port_c[k];
        end
        tag_v_q[k][0] <= u_valid_q[k];
        tag_p_q[k][0] <= u_port_q[k];
        for (int unsigned s = 1; s < latency; s++) begin
          tag_v_q[k][s] <= tag_v_q[k][s-1];
          tag_p_q[k][s] <= tag_p_q[k][s-1];
        end
      end
    end
  end

  // Registered response stage and sticky error.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      resp_valid_q <= resp_hit_c;
      err_q        <= err_q | err_c;
      for (int unsigned p = 0; p < ports; p++) begin
        if (resp_hit_c[p]) resp_data_q[p*width +: width] <= resp_res_c[p];
      end
    end
  end

  assign req_ready_o  = grant_c;
  assign u_valid_o    = u_valid_q;
  assign u_op_o       = u_op_q;
  assign u_a_o        = u_a_q;
  assign u_b_o        = u_b_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_data_o  = resp_data_q;
  assign err_o        = err_q;

endmodule

// File: doc/saph_fpu_xbar.md
Name: saph_fpu_xbar

Overview:
- Parametrised port-to-unit crossbar for the FPU. It couples P requester ports to U identical, fixed-latency FP units.
- Each cycle it grants up to min(P,U) requests using rotating-priority (round-robin) arbitration.
- It tracks the issuing port of every in-flight operation in a per-unit tag pipeline, then routes each result back to its originating port through a registered response stage.
- Replaces one-mux-per-unit wiring: any port may use any free unit, and arbitration is fair.

Parameters:
- ports, 2, number of requester ports P (>=1).
- units, 2, number of FP units U (>=1).
- width, 32, operand/result width W in bits.
- op_width, 3, opcode width OPW, passed through unmodified.
- latency, 2, unit latency L in cycles, from u_valid to u_res_valid (>=1).

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  P  per-port request valid.
- req_ready  out  P  per-port grant; a transfer occurs when req_valid&req_ready.
- req_op  in  P*OPW  per-port opcode; port p occupies bits [p*OPW +: OPW].
- req_a  in  P*W  operand A per port.
- req_b  in  P*W  operand B per port.
- resp_valid  out  P  per-port result valid, 1-cycle pulse, no backpressure.
- resp_data  out  P*W  per-port result.
- u_valid  out  U  registered issue strobe per unit.
- u_op  out  U*OPW  registered opcode per unit.
- u_a  out  U*W  registered operand A per unit.
- u_b  out  U*W  registered operand B per unit.
- u_res_valid  in  U  unit result valid.
- u_res  in  U*W  unit result.
- err  out  1  sticky protocol error flag.

Behaviour:
- Reset (async assert, sync deassert):
  - Clears u_valid, resp_valid, err, the priority pointer ptr, and all tag pipelines.
  - u_op, u_a, u_b and resp_data reset to 0.
  - Operations in flight at reset are dropped; no resp_valid is produced for them.
- Arbitration is combinational within the cycle:
  - Scan ports in order ptr, ptr+1, …, ptr+P-1 (mod P).
  - Each valid port is assigned the lowest-indexed unit not yet assigned this cycle, until units run out.
  - req_ready[p] = 1 iff port p is assigned. req_ready may depend on req_valid; req_valid must not depend on req_ready.
  - Units are always free each cycle (fully pipelined), so throughput is U ops/cycle.
- Pointer update:
  - If at least one grant occurs, ptr <= (last granted port in scan order + 1) mod P.
  - Otherwise ptr holds.
  - With P<=U every valid port is granted every cycle.
- Issue: a grant in cycle t drives u_valid[k]=1 with that port's op/a/b in cycle t+1. u_valid[k]=0 when unit k is not assigned. Operand registers hold their value when u_valid=0.
- Tag pipeline per unit:
  - An L-deep shift register of {valid, port index (clog2(P), min 1 bit)}.
  - It is loaded when u_valid[k] is issued.
  - Its output aligns with u_res_valid[k] in cycle t+1+L.
- Response:
  - In cycle t+1+L, u_res[k] is registered into resp_data[tag port]; resp_valid pulses in cycle t+2+L.
  - Total request-to-response latency is L+2 cycles.
  - A port issues at most one op per cycle and all units share L, so at most one result targets a port per cycle; no collision logic is needed.
- Error: err is set and held until reset when either of the following occurs:
  - u_res_valid[k] is 1 while the tag output is not valid. The result is discarded.
  - The tag output is valid while u_res_valid[k] is 0. resp_valid stays 0 for that slot and the tag is consumed.
- Order: results to a given port return in issue order, because latency is fixed.

Test Plan:
- P=2, U=2, L=2. Port0 sends op=1, a=0x3F800000, b=0x40000000 at cycle 5 → u_valid[0] at 6; stub unit returns 0x40400000 at 8 → resp_valid[0] at 9 with resp_data=0x40400000.
- P=3, U=1, all ports valid every cycle from reset → grants rotate 0,1,2,0,1,2; each port gets exactly 1 of every 3 cycles.
- P=4, U=2, ports 1 and 3 valid continuously, ptr=0 → cycle A grants 1→unit0 and 3→unit1; ptr becomes 0; both ports are granted every cycle.
- Back-to-back: port0 valid 10 consecutive cycles with P=1, U=1 → 10 resp_valid pulses on consecutive cycles, in order, data matching each issue.
- Assert rst with 2 ops in flight → no resp_valid afterwards; ptr=0; all outputs 0.
- Stub unit drives u_res_valid[1]=1 with no issue → err=1 and it stays 1; no resp_valid on any port.
